dma_attack_engine: RTL and testbench
====================================

DMA_ATTACK_ENGINE -- requirements
Module: dma_attack_engine

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 15'h0070, meaning the byte base address of the register window, aligned to 2^DEC_WD.
REQ-002 SHALL have parameter DEC_WD, default 4, meaning the address-decode width (16-byte window, 8 word registers).
REQ-003 SHALL have parameter CNT_WD, default 8, meaning the width of the transfer counter (max burst 2^CNT_WD-1 words).
REQ-004 SHALL have port mclk  input  1  main system clock.
REQ-005 SHALL have port puc_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port per_addr  input  14  peripheral word address.
REQ-007 SHALL have port per_din  input  16  peripheral write data.
REQ-008 SHALL have port per_en  input  1  peripheral enable.
REQ-009 SHALL have port per_we  input  2  peripheral byte write enables.
REQ-010 SHALL have port per_dout  output  16  peripheral read data.
REQ-011 SHALL have port dma_ready  input  1  DMA access accepted this cycle.
REQ-012 SHALL have port dma_dout  input  16  DMA read data, valid the cycle after acceptance.
REQ-013 SHALL have port dma_en  output  1  DMA request.
REQ-014 SHALL have port dma_addr  output  15  DMA word address.
REQ-015 SHALL have port dma_din  output  16  DMA write data.
REQ-016 SHALL have port dma_we  output  2  DMA byte write enables (2'b11 for writes, 2'b00 for reads).

Function
REQ-017 SHALL select a register when per_en=1 and per_addr[13:DEC_WD-1]==BASE_ADDR[14:DEC_WD]; offsets: 0x0 CTRL, 0x2 ADDR, 0x4 WDATA, 0x6 COUNT, 0x8 STATUS, 0xA RDATA, 0xC CHKSUM.
REQ-018 SHALL drive per_dout combinationally with the selected register on reads (per_we==0) and 16'h0 otherwise; unused offsets read 0.
REQ-019 SHALL define CTRL as: bit0 START (write-1 pulse, reads 0), bit1 DIR (1=write, 0=read), bit2 INC (address post-increment), bit3 ABORT (write-1 pulse, reads 0).
REQ-020 SHALL define STATUS (read-only) as: bit0 BUSY, bit1 DONE (sticky), bit2 ABORTED (sticky); DONE and ABORTED clear on an accepted START.
REQ-021 SHALL ignore writes to ADDR, WDATA, COUNT and CTRL.DIR/INC while BUSY=1.
REQ-022 SHALL implement FSM IDLE -> REQ -> (CAPT for reads) -> REQ|FIN -> IDLE.
REQ-023 SHALL, on START in IDLE with COUNT!=0, enter REQ next cycle; with COUNT==0, set DONE next cycle and stay IDLE.
REQ-024 SHALL ignore START while BUSY.
REQ-025 SHALL hold dma_en=1 with stable dma_addr/dma_din/dma_we throughout REQ until dma_ready=1.
REQ-026 SHALL, on acceptance, decrement the remaining count and add 1 to ADDR[15:1] if INC=1, wrapping 0xFFFE -> 0x0000.
REQ-027 SHALL, for reads, enter CAPT for one cycle with dma_en=0 and latch dma_dout into RDATA.
REQ-028 SHALL, when the remaining count reaches 0, go to FIN (BUSY=0, DONE=1) then IDLE; otherwise re-enter REQ.
REQ-029 SHALL, on ABORT in REQ without acceptance, deassert dma_en next cycle, set ABORTED and go IDLE.
REQ-030 SHALL, on ABORT coinciding with acceptance, complete that access (including CAPT) before aborting.
REQ-031 SHALL give ABORT priority over START when both are written in the same access.

Reset
REQ-032 SHALL, on puc_rst_n=0, asynchronously set all registers and outputs to 0, FSM to IDLE, dma_en=0 and dma_we=2'b00, including mid-transfer.

Configuration
REQ-033 SHALL, with DMA_ATK_CHECKSUM_EN defined, maintain CHKSUM as a 16-bit XOR of every word read (cleared on START) and an additive 16-bit wrap-around sum of every word written.
REQ-034 SHALL, without DMA_ATK_CHECKSUM_EN, read CHKSUM as 16'h0 and instantiate no checksum logic.

Verification
REQ-035 Single write: ADDR=0x0200, WDATA=0xBEEF, COUNT=1, CTRL=0x3, dma_ready=1 after 2 cycles -> one access to dma_addr 0x100, dma_we=2'b11, then DONE=1.
REQ-036 Burst read: ADDR=0x0400, COUNT=3, CTRL=0x5, memory 0x1111/0x2222/0x4444 -> addresses 0x200..0x202, RDATA=0x4444, CHKSUM=0x7777 (macro on).
REQ-037 Wrap: ADDR=0xFFFE, COUNT=2, INC=1, DIR=1 -> word addresses 0x7FFF then 0x0000.
REQ-038 Abort: dma_ready held 0, write CTRL=0x8 -> dma_en low next cycle, STATUS=0x4.
REQ-039 COUNT=0 with START -> dma_en never asserted, STATUS=0x2; START while BUSY -> no effect.
REQ-040 Reset: puc_rst_n low mid-burst -> dma_en=0 immediately, all registers read 0.

Source files
------------

// File: rtl/dma_attack_engine.sv
// Register-programmed DMA master: single/burst word reads and writes with abort.
// Optional CHKSUM register (read XOR / write sum) is enabled by defining DMA_ATK_CHECKSUM_EN.
module dma_attack_engine #(
  parameter logic [14:0] BASE_ADDR = 15'h0070,
  parameter int          DEC_WD    = 4,
  parameter int          CNT_WD    = 8
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic        dma_ready,
  input  logic [15:0] dma_dout,
  output logic        dma_en,
  output logic [14:0] dma_addr,
  output logic [15:0] dma_din,
  output logic [1:0]  dma_we
);
  localparam int IW = DEC_WD - 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAPT, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [15:0]         addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CNT_WD-1:0]   count_q, count_d, rem_q, rem_d;
  logic                dir_q, dir_d, inc_q, inc_d;
  logic                done_q, done_d, aborted_q, aborted_d, pend_q, pend_d;
  logic                sel, wr, busy, ctrl_wr, start_go, abort_go;
  logic [15:0]         off, cnt_w, chk_rd;

  function automatic logic [15:0] bmerge(input logic [15:0] old, input logic [15:0] din,
                                         input logic [1:0] we);
    return {we[1] ? din[15:8] : old[15:8], we[0] ? din[7:0] : old[7:0]};
  endfunction

  assign sel      = per_en && (per_addr[13:IW] == BASE_ADDR[14:DEC_WD]);
  assign off      = 16'({per_addr[IW-1:0], 1'b0});
  assign wr       = sel && (per_we != 2'b00);
  assign busy     = (state_q == S_REQ) || (state_q == S_CAPT);
  assign ctrl_wr  = wr && (off == 16'h0) && per_we[0];
  // ABORT wins over START when both land in the same write
  assign abort_go = ctrl_wr && per_din[3];
  assign start_go = ctrl_wr && per_din[0] && !per_din[3] && !busy;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    count_d = count_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    inc_d   = inc_q;
    done_d  = done_q;
    aborted_d = aborted_q;
    pend_d  = pend_q;
    cnt_w   = bmerge(16'(count_q), per_din, per_we);
    if (wr && !busy) begin
      case (off)
        16'h0: if (per_we[0]) begin dir_d = per_din[1]; inc_d = per_din[2]; end
        16'h2: addr_d  = bmerge(addr_q, per_din, per_we);
        16'h4: wdata_d = bmerge(wdata_q, per_din, per_we);
        16'h6: count_d = cnt_w[CNT_WD-1:0];
        default: ;
      endcase
    end
    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (start_go) begin
          aborted_d = 1'b0;
          pend_d    = 1'b0;
          if (count_q == '0) done_d = 1'b1;
          else begin
            done_d  = 1'b0;
            rem_d   = count_q;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dma_ready) begin
          rem_d = rem_q - 1'b1;
          if (inc_q) addr_d = {addr_q[15:1] + 15'd1, addr_q[0]};
          // an abort that coincides with acceptance lets the read finish its capture
          if (!dir_q) begin
            state_d = S_CAPT;
            pend_d  = abort_go;
          end else if (abort_go) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
          end else if (rem_d == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end
        end else if (abort_go) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end
      end
      S_CAPT: begin
        rdata_d = dma_dout;
        if (abort_go || pend_q) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
          pend_d    = 1'b0;
        end else if (rem_q == '0) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      count_q <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      inc_q   <= 1'b0;
      done_q  <= 1'b0;
      aborted_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      inc_q   <= inc_d;
      done_q  <= done_d;
      aborted_q <= aborted_d;
      pend_q  <= pend_d;
    end
  end

`ifdef DMA_ATK_CHECKSUM_EN
  logic [15:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (start_go) chk_d = 16'h0;
    else if (state_q == S_REQ && dma_ready && dir_q) chk_d = chk_q + wdata_q;
    else if (state_q == S_CAPT) chk_d = chk_q ^ dma_dout;
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) chk_q <= '0;
    else            chk_q <= chk_d;
  end

  assign chk_rd = chk_q;
`else
  assign chk_rd = 16'h0;
`endif

  always_comb begin
    per_dout = 16'h0;
    if (sel && per_we == 2'b00) begin
      case (off)
        16'h0: per_dout = {13'h0, inc_q, dir_q, 1'b0};
        16'h2: per_dout = addr_q;
        16'h4: per_dout = wdata_q;
        16'h6: per_dout = 16'(count_q);
        16'h8: per_dout = {13'h0, aborted_q, done_q, busy};
        16'hA: per_dout = rdata_q;
        16'hC: per_dout = chk_rd;
        default: per_dout = 16'h0;
      endcase
    end
  end

  assign dma_en   = (state_q == S_REQ);
  assign dma_we   = (state_q == S_REQ && dir_q) ? 2'b11 : 2'b00;
  assign dma_addr = addr_q[15:1];
  assign dma_din  = wdata_q;
endmodule

// File: tb/tb_dma_attack_engine.sv
// Directed bench for dma_attack_engine: register access, write/read bursts, wrap, abort, reset.
module tb_dma_attack_engine;
  logic        mclk = 1'b0;
  logic        puc_rst_n = 1'b0;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = 2'b00;
  logic [15:0] per_dout;
  logic        dma_ready;
  logic [15:0] dma_dout = '0;
  logic        dma_en;
  logic [14:0] dma_addr;
  logic [15:0] dma_din;
  logic [1:0]  dma_we;

  localparam logic [13:0] PBASE = 14'h0038;
`ifdef DMA_ATK_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // memory responder state
  bit          rdy_en = 1'b1;
  int          rdy_delay = 0;
  int          wait_cnt = 0;
  int          acc_n = 0;
  int          en_cycles = 0;
  logic [14:0] acc_addr [64];
  logic [1:0]  acc_we   [64];
  logic [15:0] acc_din  [64];

  dma_attack_engine dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we), .per_dout(per_dout), .dma_ready(dma_ready),
    .dma_dout(dma_dout), .dma_en(dma_en), .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_we(dma_we)
  );

  always #5 mclk = ~mclk;

  function automatic logic [15:0] mem_rd(input logic [14:0] a);
    case (a)
      15'h0200: return 16'h1111;
      15'h0201: return 16'h2222;
      15'h0202: return 16'h4444;
      default:  return {1'b0, a} ^ 16'hA5A5;
    endcase
  endfunction

  assign dma_ready = dma_en && rdy_en && (wait_cnt >= rdy_delay);

  always @(posedge mclk) begin
    en_cycles <= en_cycles + (dma_en ? 1 : 0);
    if (dma_en && dma_ready) begin
      acc_addr[acc_n[5:0]] <= dma_addr;
      acc_we[acc_n[5:0]]   <= dma_we;
      acc_din[acc_n[5:0]]  <= dma_din;
      acc_n    <= acc_n + 1;
      dma_dout <= mem_rd(dma_addr);
      wait_cnt <= 0;
    end else if (dma_en) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [15:0] d);
    per_en = 1'b1; per_we = 2'b11; per_addr = PBASE + {11'h0, idx}; per_din = d;
    @(negedge mclk);
    per_en = 1'b0; per_we = 2'b00;
  endtask

  task automatic rd(input logic [2:0] idx, output logic [15:0] d);
    per_en = 1'b1; per_we = 2'b00; per_addr = PBASE + {11'h0, idx};
    #1 d = per_dout;
    per_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [15:0] exp);
    logic [15:0] v;
    rd(idx, v);
    check(tag, v, exp);
  endtask

  task automatic wait_done(input string tag);
    logic [15:0] s;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge mclk);
      rd(3'd4, s);
      if (!s[0] && s[2:1] != 2'b00) ok = 1'b1;
    end
    check({tag, "_timeout"}, ok, 1);
    @(negedge mclk);
    @(negedge mclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, e0;
    // reset state
    #3;
    for (int i = 0; i < 7; i++) rd_chk($sformatf("rst_reg%0d", i), 3'(i), 16'h0);
    check("rst_dma_en", dma_en, 0);
    check("rst_dma_we", dma_we, 0);
    #9 puc_rst_n = 1'b1;
    @(negedge mclk);

    // single write with 2-cycle ready latency; START/COUNT/ADDR writes while busy ignored
    rdy_delay = 2;
    wr(3'd1, 16'h0200);
    wr(3'd2, 16'hBEEF);
    wr(3'd3, 16'h0001);
    base = acc_n;
    wr(3'd0, 16'h0003);
    check("sw_dma_en", dma_en, 1);
    check("sw_dma_addr", dma_addr, 15'h0100);
    check("sw_dma_we", dma_we, 2'b11);
    check("sw_dma_din", dma_din, 16'hBEEF);
    rd_chk("sw_busy", 3'd4, 16'h0001);
    wr(3'd3, 16'h0005);
    wr(3'd0, 16'h0001);
    wr(3'd1, 16'h0AAA);
    wait_done("sw");
    check("sw_acc_n", acc_n - base, 1);
    check("sw_acc_addr", acc_addr[base], 15'h0100);
    check("sw_acc_we", acc_we[base], 2'b11);
    check("sw_acc_din", acc_din[base], 16'hBEEF);
    rd_chk("sw_status", 3'd4, 16'h0002);
    rd_chk("sw_count", 3'd3, 16'h0001);
    rd_chk("sw_addr", 3'd1, 16'h0200);
    rd_chk("sw_chk", 3'd6, CK ? 16'hBEEF : 16'h0);
    rd_chk("sw_ctrl", 3'd0, 16'h0002);

    // burst read with post-increment
    rdy_delay = 0;
    @(negedge mclk);
    wr(3'd1, 16'h0400);
    wr(3'd3, 16'h0003);
    base = acc_n;
    wr(3'd0, 16'h0005);
    wait_done("br");
    check("br_acc_n", acc_n - base, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("br_addr%0d", i), acc_addr[base + i], 15'h0200 + 15'(i));
      check($sformatf("br_we%0d", i), acc_we[base + i], 2'b00);
    end
    rd_chk("br_rdata", 3'd5, 16'h4444);
    rd_chk("br_chk", 3'd6, CK ? 16'h7777 : 16'h0);
    rd_chk("br_addr", 3'd1, 16'h0406);
    rd_chk("br_status", 3'd4, 16'h0002);

    // address wrap on increment
    @(negedge mclk);
    wr(3'd1, 16'hFFFE);
    wr(3'd2, 16'h1234);
    wr(3'd3, 16'h0002);
    base = acc_n;
    wr(3'd0, 16'h0007);
    wait_done("wr");
    check("wr_acc_n", acc_n - base, 2);
    check("wr_addr0", acc_addr[base], 15'h7FFF);
    check("wr_addr1", acc_addr[base + 1], 15'h0000);
    check("wr_we1", acc_we[base + 1], 2'b11);
    rd_chk("wr_addr", 3'd1, 16'h0002);
    rd_chk("wr_chk", 3'd6, CK ? 16'h2468 : 16'h0);

    // abort while stalled, then ABORT+START together in idle
    rdy_en = 1'b0;
    @(negedge mclk);
    wr(3'd1, 16'h0100);
    wr(3'd3, 16'h0004);
    base = acc_n;
    wr(3'd0, 16'h0003);
    check("ab_dma_en_req", dma_en, 1);
    wr(3'd0, 16'h0008);
    check("ab_dma_en_low", dma_en, 0);
    rd_chk("ab_status", 3'd4, 16'h0004);
    check("ab_acc_n", acc_n - base, 0);
    wr(3'd0, 16'h0009);
    @(negedge mclk);
    rd_chk("ab_prio_status", 3'd4, 16'h0004);
    check("ab_prio_dma_en", dma_en, 0);
    rdy_en = 1'b1;

    // abort coinciding with an accepted read completes the capture
    @(negedge mclk);
    wr(3'd1, 16'h0400);
    wr(3'd3, 16'h0003);
    base = acc_n;
    wr(3'd0, 16'h0005);
    wr(3'd0, 16'h0008);
    wait_done("aa");
    check("aa_acc_n", acc_n - base, 1);
    rd_chk("aa_rdata", 3'd5, 16'h1111);
    rd_chk("aa_status", 3'd4, 16'h0004);
    rd_chk("aa_addr", 3'd1, 16'h0402);

    // COUNT=0 start: done without any request
    @(negedge mclk);
    wr(3'd3, 16'h0000);
    e0 = en_cycles;
    base = acc_n;
    wr(3'd0, 16'h0003);
    rd_chk("c0_status", 3'd4, 16'h0002);
    repeat (3) @(negedge mclk);
    check("c0_en_cycles", en_cycles - e0, 0);
    check("c0_acc_n", acc_n - base, 0);

    // reset in the middle of a burst
    @(negedge mclk);
    wr(3'd1, 16'h0400);
    wr(3'd3, 16'h0003);
    wr(3'd0, 16'h0005);
    check("mr_dma_en_before", dma_en, 1);
    #2 puc_rst_n = 1'b0;
    #1;
    check("mr_dma_en", dma_en, 0);
    check("mr_dma_we", dma_we, 2'b00);
    check("mr_dma_addr", dma_addr, 15'h0);
    for (int i = 0; i < 7; i++) rd_chk($sformatf("mr_reg%0d", i), 3'(i), 16'h0);
    @(negedge mclk);
    #2 puc_rst_n = 1'b1;
    @(negedge mclk);
    @(negedge mclk);
    check("mr_dma_en_after", dma_en, 0);
    rd_chk("mr_status_after", 3'd4, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
